// File: rtl/argmax_pkg.sv
// Shared types and helpers for the sequential argmax scanner.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width for n classes; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : argmax_pkg

// File: rtl/argmax_update.sv
// Combinational best/runner-up update for one candidate score.
module argmax_update
  import argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned WEIGHT_W    = 4,
  parameter bit          TIE_LAST    = 1'b1,
  localparam int unsigned IDX_W      = idx_w(NUM_CLASSES)
) (
  input  logic [WEIGHT_W-1:0] cand_i,
  input  logic [IDX_W-1:0]    cand_idx_i,
  input  logic [WEIGHT_W-1:0] best_i,
  input  logic [IDX_W-1:0]    best_idx_i,
  input  logic [WEIGHT_W-1:0] second_i,
  input  logic                first_i,
  output logic [WEIGHT_W-1:0] best_c_o,
  output logic [IDX_W-1:0]    best_idx_c_o,
  output logic [WEIGHT_W-1:0] second_c_o
);

  logic take;

  always_comb begin
    best_c_o     = best_i;
    best_idx_c_o = best_idx_i;
    second_c_o   = second_i;
    take         = (cand_i > best_i) || (TIE_LAST && (cand_i == best_i));
    if (first_i) begin
      best_c_o     = cand_i;
      best_idx_c_o = cand_idx_i;
    end else if (take) begin
      // Displaced best becomes the runner-up.
      best_c_o     = cand_i;
      best_idx_c_o = cand_idx_i;
      second_c_o   = best_i;
    end else if (cand_i >= second_i) begin
      second_c_o = cand_i;
    end
  end

endmodule : argmax_update

// File: rtl/argmax_scan.sv
// Sequential argmax: captures all scores on start, scans one class per cycle,
// then presents winner, runner-up, margin and confidence for one DONE cycle.
module argmax_scan
  import argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned WEIGHT_W    = 4,
  parameter bit          TIE_LAST    = 1'b1,
  localparam int unsigned IDX_W      = idx_w(NUM_CLASSES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic [NUM_CLASSES*WEIGHT_W-1:0] weights_i,
  input  logic [WEIGHT_W-1:0]             conf_margin_i,
  output logic                            busy_o,
  output logic                            result_valid_o,
  output logic [IDX_W-1:0]                max_idx_o,
  output logic [WEIGHT_W-1:0]             max_val_o,
  output logic [WEIGHT_W-1:0]             second_val_o,
  output logic [WEIGHT_W-1:0]             margin_o,
  output logic                            confident_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_e                                 state_q, state_d;
  logic [NUM_CLASSES-1:0][WEIGHT_W-1:0]   hold_q, hold_d;
  logic [WEIGHT_W-1:0]                    conf_q, conf_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [WEIGHT_W-1:0]                    best_q, best_d;
  logic [IDX_W-1:0]                       best_idx_q, best_idx_d;
  logic [WEIGHT_W-1:0]                    second_q, second_d;
  logic                                   first_q, first_d;
  logic                                   busy_q, busy_d;
  logic                                   valid_q, valid_d;
  logic [IDX_W-1:0]                       max_idx_q, max_idx_d;
  logic [WEIGHT_W-1:0]                    max_val_q, max_val_d;
  logic [WEIGHT_W-1:0]                    second_val_q, second_val_d;
  logic [WEIGHT_W-1:0]                    margin_q, margin_d;
  logic                                   confident_q, confident_d;

  logic [WEIGHT_W-1:0]                    upd_best_c;
  logic [IDX_W-1:0]                       upd_best_idx_c;
  logic [WEIGHT_W-1:0]                    upd_second_c;
  logic [WEIGHT_W-1:0]                    margin_c;

  argmax_update #(
    .NUM_CLASSES (NUM_CLASSES),
    .WEIGHT_W    (WEIGHT_W),
    .TIE_LAST    (TIE_LAST)
  ) u_update (
    .cand_i       (hold_q[idx_q]),
    .cand_idx_i   (idx_q),
    .best_i       (best_q),
    .best_idx_i   (best_idx_q),
    .second_i     (second_q),
    .first_i      (first_q),
    .best_c_o     (upd_best_c),
    .best_idx_c_o (upd_best_idx_c),
    .second_c_o   (upd_second_c)
  );

  // Best can never fall below second, so this subtraction cannot underflow.
  assign margin_c = upd_best_c - upd_second_c;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    conf_d       = conf_q;
    idx_d        = idx_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    second_d     = second_q;
    first_d      = first_q;
    valid_d      = 1'b0;
    max_idx_d    = max_idx_q;
    max_val_d    = max_val_q;
    second_val_d = second_val_q;
    margin_d     = margin_q;
    confident_d  = confident_q;

    // start wins in every state, which also aborts a scan in flight.
    if (start_i) begin
      state_d    = SCAN;
      hold_d     = weights_i;
      conf_d     = conf_margin_i;
      idx_d      = '0;
      best_d     = '0;
      best_idx_d = '0;
      second_d   = '0;
      first_d    = 1'b1;
    end else begin
      unique case (state_q)
        SCAN: begin
          best_d     = upd_best_c;
          best_idx_d = upd_best_idx_c;
          second_d   = upd_second_c;
          first_d    = 1'b0;
          idx_d      = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d      = DONE;
            valid_d      = 1'b1;
            max_idx_d    = upd_best_idx_c;
            max_val_d    = upd_best_c;
            second_val_d = upd_second_c;
            margin_d     = margin_c;
            confident_d  = (margin_c >= conf_q);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      conf_q       <= '0;
      idx_q        <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      second_q     <= '0;
      first_q      <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      max_idx_q    <= '0;
      max_val_q    <= '0;
      second_val_q <= '0;
      margin_q     <= '0;
      confident_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      conf_q       <= conf_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      second_q     <= second_d;
      first_q      <= first_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      max_idx_q    <= max_idx_d;
      max_val_q    <= max_val_d;
      second_val_q <= second_val_d;
      margin_q     <= margin_d;
      confident_q  <= confident_d;
    end
  end

  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign max_idx_o      = max_idx_q;
  assign max_val_o      = max_val_q;
  assign second_val_o   = second_val_q;
  assign margin_o       = margin_q;
  assign confident_o    = confident_q;

endmodule : argmax_scan
